ysyx_dmem_responder: RTL and testbench

Memory-side responder for the EXU's data load/store traffic. Accepts one request at a time (read or byte-masked write) over a valid/ready request channel. Returns a response on a valid/ready response channel after a programmable latency. Backs a word-addressed on-chip data RAM, so NPC simulation can move off direct DPI pmem calls toward a handshaked bus.

---
 rtl/ysyx_mem_pkg.sv | 15 +
 rtl/ysyx_sram_array.sv | 36 +++
 rtl/ysyx_dmem_responder.sv | 140 ++++++++++++++
 tb/tb_ysyx_dmem_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_mem_pkg.sv
// Shared definitions for the EXU data-memory path: bus widths, the default
// data-RAM base address and the responder FSM state type.
package ysyx_mem_pkg;

    localparam int          DATA_W            = 32;
    localparam int          MASK_W            = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/ysyx_sram_array.sv
// Word-organised data RAM with per-byte write enables and a registered read
// port; both ports act on the same clock edge when enabled.
module ysyx_sram_array
    import ysyx_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [MASK_W-1:0] wmask_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wmask_i[i]) begin
                    mem[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_dmem_responder.sv
// Handshaked responder for EXU loads/stores: one outstanding request, fixed
// programmable latency, range-checked access to the on-chip data RAM.
module ysyx_dmem_responder
    import ysyx_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              wen_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              respValid_q;
    logic              respErr_q;
    logic              readSel_q;

    logic              accept;
    logic              commit;
    logic              cWen;
    logic [31:0]       cAddr;
    logic [DATA_W-1:0] cWdata;
    logic [MASK_W-1:0] cMask;
    logic [31:0]       offset;
    logic              inRange;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] sramRdata;

    // With LATENCY=1 the commit edge is the accept edge, so the live request
    // fields feed the RAM; otherwise the latched copy does.
    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
        accept    = req_valid && req_ready;
        if (state_q == IDLE) begin
            cWen   = req_wen;
            cAddr  = req_addr;
            cWdata = req_wdata;
            cMask  = req_wmask;
        end else begin
            cWen   = wen_q;
            cAddr  = addr_q;
            cWdata = wdata_q;
            cMask  = wmask_q;
        end
        offset  = cAddr - BASE_ADDR;
        inRange = offset < SPAN;
        index   = offset[IDX_W+1:2];
        commit  = 1'b0;
        if (!rst) begin
            if (state_q == IDLE) begin
                commit = accept && (LATENCY == 1);
            end else if (state_q == WAIT) begin
                commit = (cnt_q == 4'd0);
            end
        end
    end

    ysyx_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clk     (clk),
        .we_i    (commit && cWen && inRange),
        .re_i    (commit && !cWen && inRange),
        .idx_i   (index),
        .wdata_i (cWdata),
        .wmask_i (cMask),
        .rdata_o (sramRdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            respValid_q <= 1'b0;
            respErr_q   <= 1'b0;
            readSel_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        wen_q   <= req_wen;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wmask_q <= req_wmask;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q     <= IDLE;
                        respValid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (commit) begin
                respValid_q <= 1'b1;
                respErr_q   <= !inRange;
                readSel_q   <= !cWen && inRange;
            end
        end
    end

    assign resp_valid = respValid_q;
    assign resp_err   = respErr_q;
    assign resp_rdata = readSel_q ? sramRdata : '0;

endmodule

// File: tb/tb_ysyx_dmem_responder.sv
// Drives three responders (LATENCY 1, 3, 4) with shared stimulus and checks
// every cycle against a timestamp-based transaction model of the data RAM.
module tb_ysyx_dmem_responder;

    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          NDUT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_ready;

    logic        reqReady  [NDUT];
    logic        respValid [NDUT];
    logic [31:0] respRdata [NDUT];
    logic        respErr   [NDUT];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(reqReady[0]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(respValid[0]), .resp_ready(resp_ready), .resp_rdata(respRdata[0]), .resp_err(respErr[0]));
    ysyx_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(reqReady[1]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(respValid[1]), .resp_ready(resp_ready), .resp_rdata(respRdata[1]), .resp_err(respErr[1]));
    ysyx_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(4)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(reqReady[2]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(respValid[2]), .resp_ready(resp_ready), .resp_rdata(respRdata[2]), .resp_err(respErr[2]));

    function automatic int latOf(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: an accepted request is stamped with the edge at which
    // its result must appear; the model memory is an array of words.
    int          edgeCnt = 0;
    bit          mBusy   [NDUT];
    bit          mValid  [NDUT];
    int          mCommit [NDUT];
    logic        tWen    [NDUT];
    logic [31:0] tAddr   [NDUT];
    logic [31:0] tWdata  [NDUT];
    logic [3:0]  tMask   [NDUT];
    logic [31:0] mRdata  [NDUT];
    logic        mErr    [NDUT];
    logic [31:0] mMem    [NDUT][DEPTH];

    always @(posedge clk) begin
        bit          wasBusy;
        logic [31:0] off;
        edgeCnt++;
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                mBusy[k]  = 1'b0;
                mValid[k] = 1'b0;
                mRdata[k] = 32'h0;
                mErr[k]   = 1'b0;
            end else begin
                wasBusy = mBusy[k];
                if (mValid[k] && resp_ready) begin
                    mBusy[k]  = 1'b0;
                    mValid[k] = 1'b0;
                end
                if (!wasBusy && req_valid) begin
                    mBusy[k]   = 1'b1;
                    tWen[k]    = req_wen;
                    tAddr[k]   = req_addr;
                    tWdata[k]  = req_wdata;
                    tMask[k]   = req_wmask;
                    mCommit[k] = edgeCnt + latOf(k) - 1;
                end
                if (mBusy[k] && !mValid[k] && edgeCnt == mCommit[k]) begin
                    off = tAddr[k] - BASE;
                    mValid[k] = 1'b1;
                    mRdata[k] = 32'h0;
                    mErr[k]   = !(off < 32'(4 * DEPTH));
                    if (!mErr[k]) begin
                        if (tWen[k]) begin
                            for (int b = 0; b < 4; b++)
                                if (tMask[k][b]) mMem[k][off[6:2]][8*b +: 8] = tWdata[k][8*b +: 8];
                        end else begin
                            mRdata[k] = mMem[k][off[6:2]];
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison plus capture of observed handshake timing/data.
    int          accCyc   [NDUT];
    int          latMeas  [NDUT];
    int          accCount [NDUT];
    bit          prevValid[NDUT];
    logic [31:0] lastRdata[NDUT];
    logic        lastErr  [NDUT];

    initial for (int k = 0; k < NDUT; k++) begin
        accCount[k] = 0;
        prevValid[k] = 1'b0;
        latMeas[k] = 0;
        accCyc[k] = 0;
    end

    always @(negedge clk) begin
        if (edgeCnt >= 1) begin
            for (int k = 0; k < NDUT; k++) begin
                checkOutput($sformatf("dut%0d_req_ready", k), 32'(reqReady[k]), 32'(!mBusy[k] && !rst));
                checkOutput($sformatf("dut%0d_resp_valid", k), 32'(respValid[k]), 32'(mValid[k]));
                checkOutput($sformatf("dut%0d_resp_rdata", k), respRdata[k], mRdata[k]);
                checkOutput($sformatf("dut%0d_resp_err", k), 32'(respErr[k]), 32'(mErr[k]));
                if (reqReady[k] === 1'b1 && req_valid && !rst) begin
                    accCyc[k] = edgeCnt;
                    accCount[k]++;
                end
                if (respValid[k] === 1'b1 && !prevValid[k]) latMeas[k] = edgeCnt - accCyc[k];
                if (respValid[k] === 1'b1 && resp_ready) begin
                    lastRdata[k] = respRdata[k];
                    lastErr[k]   = respErr[k];
                end
                prevValid[k] = (respValid[k] === 1'b1);
            end
        end
    end

    function automatic logic [31:0] randAddr();
        int sel = $urandom_range(0, 7);
        if (sel == 0) return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
        if (sel == 1) return BASE - 32'($urandom_range(1, 64));
        return BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
    endfunction

    // One request pulse, optional noisy window, then a drain back to idle.
    task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] mask, input bit noisy);
        @(posedge clk); #1;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
        resp_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (noisy) begin
            repeat (8) begin
                resp_ready = 1'($urandom_range(0, 1));
                req_valid  = ($urandom_range(0, 2) == 0);
                req_wen    = 1'($urandom_range(0, 1));
                req_addr   = randAddr();
                req_wdata  = $urandom;
                req_wmask  = 4'($urandom_range(0, 15));
                @(posedge clk); #1;
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (7) @(posedge clk);
    endtask

    task automatic expectAll(input string name, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic err);
        checkOutput({name, "_rdata0"}, lastRdata[0], e0);
        checkOutput({name, "_rdata1"}, lastRdata[1], e1);
        checkOutput({name, "_rdata2"}, lastRdata[2], e2);
        for (int k = 0; k < NDUT; k++) checkOutput({name, "_err"}, 32'(lastErr[k]), 32'(err));
    endtask

    int accSnap[NDUT];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_wmask = 4'h0; resp_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, BASE + 32'(4 * i), 32'h5A5A_0000 + 32'(i), 4'hF, 1'b0);

        // Write then read back, with first-response latency per instance.
        applyStimulus(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        applyStimulus(1'b0, BASE + 32'h10, 32'h0, 4'h0, 1'b0);
        expectAll("wr_rd", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        for (int k = 0; k < NDUT; k++) checkOutput("latency", 32'(latMeas[k]), 32'(latOf(k)));
        checkOutput("pin_wr_rd", mMem[0][4], 32'hDEADBEEF);

        // Byte-lane merge.
        applyStimulus(1'b1, BASE + 32'h20, 32'h11223344, 4'hF, 1'b0);
        applyStimulus(1'b1, BASE + 32'h20, 32'h0000AA00, 4'b0010, 1'b0);
        applyStimulus(1'b0, BASE + 32'h20, 32'h0, 4'h0, 1'b0);
        expectAll("lanes", 32'h1122AA44, 32'h1122AA44, 32'h1122AA44, 1'b0);
        checkOutput("pin_lanes", mMem[2][8], 32'h1122AA44);

        // Backpressure: response held for ten cycles.
        @(posedge clk); #1;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 32'h10; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 resp_ready = 1'b1;
        repeat (7) @(posedge clk);
        checkOutput("bp_latency4", 32'(latMeas[2]), 32'd4);
        expectAll("bp", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

        // Out-of-range accesses leave the edge words untouched.
        applyStimulus(1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 1'b0);
        expectAll("oor_wr", 32'h0, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, 1'b0);
        expectAll("oor_rd", 32'h0, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, BASE, 32'h0, 4'h0, 1'b0);
        expectAll("word0", 32'h5A5A_0000, 32'h5A5A_0000, 32'h5A5A_0000, 1'b0);
        applyStimulus(1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, 1'b0);
        expectAll("wordlast", 32'h5A5A_001F, 32'h5A5A_001F, 32'h5A5A_001F, 1'b0);

        // Reset one cycle after a write is accepted.
        @(posedge clk); #1;
        req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE + 32'h40; req_wdata = 32'hCAFEF00D; req_wmask = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (7) @(posedge clk);
        applyStimulus(1'b0, BASE + 32'h40, 32'h0, 4'h0, 1'b0);
        expectAll("rst_mid", 32'hCAFEF00D, 32'h5A5A_0010, 32'h5A5A_0010, 1'b0);
        checkOutput("pin_rst_mid", mMem[1][16], 32'h5A5A_0010);

        // Request held during RESP is taken only after returning to idle.
        for (int k = 0; k < NDUT; k++) accSnap[k] = accCount[k];
        @(posedge clk); #1;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 32'h10; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_wen = 1'b1; req_addr = BASE + 32'h14; req_wdata = 32'h12345678; req_wmask = 4'hF;
        repeat (5) @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        for (int k = 0; k < NDUT; k++) checkOutput("ignored_accepts", 32'(accCount[k] - accSnap[k]), 32'd2);
        applyStimulus(1'b0, BASE + 32'h14, 32'h0, 4'h0, 1'b0);
        expectAll("ignored_rd", 32'h12345678, 32'h12345678, 32'h12345678, 1'b0);

        // Randomised traffic with random backpressure and stray requests.
        for (int n = 0; n < 80; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), randAddr(), $urandom, 4'($urandom_range(0, 15)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
